// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - MIPS 32x32 register file with in-order write-back buffer and forwarding reads
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       commit_en,
    input  logic [ADDR_W-1:0]          rd_addr1,
    output logic [DATA_W-1:0]          rd_data1,
    input  logic [ADDR_W-1:0]          rd_addr2,
    output logic [DATA_W-1:0]          rd_data2,
    output logic [$clog2(DEPTH):0]     wb_count,
    output logic                       wb_empty
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] regs     [NREGS];
    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic accept;
    logic push;
    logic pop;

    assign wb_ready = (count < CNT_W'(DEPTH));
    assign wb_count = count;
    assign wb_empty = (count == '0);

    // Writes to $0 complete the handshake but never occupy a buffer slot.
    assign accept = wb_valid && wb_ready;
    assign push   = accept && (wb_addr != '0);
    assign pop    = commit_en && (count != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                regs[buf_addr[rd_ptr]] <= buf_data[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Buffer payload needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= wb_addr;
            buf_data[wr_ptr] <= wb_data;
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [PTR_W-1:0]  scan_idx;

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;
    assign rd_data1   = rd_data[0];
    assign rd_data2   = rd_data[1];

    // Scan oldest to youngest so the youngest buffered match wins.
    always_comb begin
        scan_idx = '0;
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            for (int k = 0; k < DEPTH; k++) begin
                scan_idx = rd_ptr + PTR_W'(k);
                if ((CNT_W'(k) < count) && (buf_addr[scan_idx] == rd_addr[p])) begin
                    rd_data[p] = buf_data[scan_idx];
                end
            end
            if (accept && (wb_addr == rd_addr[p])) begin
                rd_data[p] = wb_data;
            end
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - directed table plus randomized model-checked bench for regfile_wb
module tb_regfile_wb;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        commit_en;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data2;
    logic [1:0]  wb_count;
    logic        wb_empty;

    regfile_wb #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .commit_en(commit_en),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2),
        .wb_count(wb_count), .wb_empty(wb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        ce;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        rdy;
        logic [1:0]  cnt;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mregs [32];
    vec_t        tbl [24];

    function automatic vec_t mk(logic rst, logic v, logic [4:0] a, logic [31:0] d, logic ce,
                                logic [4:0] r1, logic [4:0] r2, logic rdy, logic [1:0] cnt,
                                logic [31:0] e1, logic [31:0] e2);
        vec_t t;
        t.rst = rst; t.v = v; t.a = a; t.d = d; t.ce = ce; t.r1 = r1; t.r2 = r2;
        t.rdy = rdy; t.cnt = cnt; t.e1 = e1; t.e2 = e2;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_valid && (q.size() < DEPTH) && (wb_addr == a)) return wb_data;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == a) return q[i].d;
        end
        return mregs[a];
    endfunction

    task automatic drive(logic rst, logic v, logic [4:0] a, logic [31:0] d, logic ce,
                         logic [4:0] r1, logic [4:0] r2);
        @(negedge clk);
        rst_n = rst; wb_valid = v; wb_addr = a; wb_data = d;
        commit_en = ce; rd_addr1 = r1; rd_addr2 = r2;
        #1;
    endtask

    task automatic advance();
        bit   acc;
        ent_t e;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        end else begin
            acc = wb_valid && (q.size() < DEPTH) && (wb_addr != 0);
            if (commit_en && q.size() > 0) begin
                e = q.pop_front();
                mregs[e.a] = e.d;
            end
            if (acc) begin
                e.a = wb_addr;
                e.d = wb_data;
                q.push_back(e);
            end
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, "_ready"}, 32'(wb_ready), 32'(q.size() < DEPTH));
        chk({tag, "_count"}, 32'(wb_count), 32'(q.size()));
        chk({tag, "_empty"}, 32'(wb_empty), 32'(q.size() == 0));
        chk({tag, "_rd1"}, rd_data1, model_read(rd_addr1));
        chk({tag, "_rd2"}, rd_data2, model_read(rd_addr2));
    endtask

    initial begin
        logic        v_h;
        logic [4:0]  a_h;
        logic [31:0] d_h;
        logic        rst_r;

        tbl[0]  = mk(1, 1, 5,  32'hDEADBEEF, 1, 5, 0,  1, 0, 32'hDEADBEEF, 32'h0);
        tbl[1]  = mk(1, 0, 0,  32'h0,        1, 5, 5,  1, 1, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[2]  = mk(1, 0, 0,  32'h0,        0, 5, 0,  1, 0, 32'hDEADBEEF, 32'h0);
        tbl[3]  = mk(1, 1, 3,  32'h11,       0, 3, 3,  1, 0, 32'h11, 32'h11);
        tbl[4]  = mk(1, 1, 3,  32'h22,       0, 3, 3,  1, 1, 32'h22, 32'h22);
        tbl[5]  = mk(1, 1, 4,  32'h33,       0, 4, 3,  0, 2, 32'h0,  32'h22);
        tbl[6]  = mk(1, 1, 4,  32'h33,       1, 4, 3,  0, 2, 32'h0,  32'h22);
        tbl[7]  = mk(1, 1, 4,  32'h33,       1, 4, 3,  1, 1, 32'h33, 32'h22);
        tbl[8]  = mk(1, 0, 0,  32'h0,        1, 4, 3,  1, 1, 32'h33, 32'h22);
        tbl[9]  = mk(1, 0, 0,  32'h0,        0, 4, 3,  1, 0, 32'h33, 32'h22);
        tbl[10] = mk(1, 1, 0,  32'hFFFFFFFF, 1, 0, 0,  1, 0, 32'h0,  32'h0);
        tbl[11] = mk(1, 0, 0,  32'h0,        0, 0, 5,  1, 0, 32'h0,  32'hDEADBEEF);
        tbl[12] = mk(1, 1, 6,  32'h66,       0, 6, 7,  1, 0, 32'h66, 32'h0);
        tbl[13] = mk(1, 1, 7,  32'hA5,       1, 7, 6,  1, 1, 32'hA5, 32'h66);
        tbl[14] = mk(1, 0, 0,  32'h0,        0, 7, 6,  1, 1, 32'hA5, 32'h66);
        tbl[15] = mk(1, 0, 0,  32'h0,        1, 7, 7,  1, 1, 32'hA5, 32'hA5);
        tbl[16] = mk(1, 0, 0,  32'h0,        0, 7, 6,  1, 0, 32'hA5, 32'h66);
        tbl[17] = mk(1, 1, 9,  32'h99,       0, 9, 10, 1, 0, 32'h99, 32'h0);
        tbl[18] = mk(1, 1, 10, 32'h1010,     0, 9, 10, 1, 1, 32'h99, 32'h1010);
        tbl[19] = mk(0, 0, 0,  32'h0,        0, 9, 10, 0, 2, 32'h99, 32'h1010);
        tbl[20] = mk(1, 0, 0,  32'h0,        1, 9, 10, 1, 0, 32'h0,  32'h0);
        tbl[21] = mk(1, 0, 0,  32'h0,        0, 5, 3,  1, 0, 32'h0,  32'h0);
        tbl[22] = mk(0, 1, 12, 32'hC,        1, 0, 0,  1, 0, 32'h0,  32'h0);
        tbl[23] = mk(1, 0, 0,  32'h0,        1, 12, 0, 1, 0, 32'h0,  32'h0);

        rst_n = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
        commit_en = 0; rd_addr1 = 0; rd_addr2 = 0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            advance();
        end

        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            chk($sformatf("reset_rd1_r%0d", i), rd_data1, 32'h0);
            chk($sformatf("reset_rd2_r%0d", 31 - i), rd_data2, 32'h0);
            chk("reset_ready", 32'(wb_ready), 32'h1);
            chk("reset_count", 32'(wb_count), 32'h0);
            advance();
        end

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].ce, tbl[i].r1, tbl[i].r2);
            chk($sformatf("tbl%0d_ready", i), 32'(wb_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_count", i), 32'(wb_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_empty", i), 32'(wb_empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("tbl%0d_rd1", i), rd_data1, tbl[i].e1);
            chk($sformatf("tbl%0d_rd2", i), rd_data2, tbl[i].e2);
            advance();
        end

        // Random traffic; a refused request is held until accepted, as a real source must.
        v_h = 0; a_h = 0; d_h = 0;
        for (int c = 0; c < 800; c++) begin
            rst_r = ($urandom_range(0, 79) != 0);
            if (!(v_h && !(q.size() < DEPTH)) || !rst_r) begin
                v_h = ($urandom_range(0, 9) < 6);
                a_h = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
                d_h = $urandom;
            end
            drive(rst_r, v_h, a_h, d_h, ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            check_model("rand");
            if (wb_valid && (q.size() < DEPTH)) v_h = 0;
            advance();
        end

        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0, 1, 5'(i), 5'(i ^ 5'd21));
            check_model("drain");
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Write-back end of the register-destination path: takes the 5-bit destination register number and result data produced upstream and commits them into a 32x32 MIPS general register file.
- A small in-order write-back buffer with valid/ready handshake absorbs write-back bursts while the array write port is unavailable (commit_en low).
- Two combinational read ports serve decode with full forwarding from incoming and buffered writes.
- Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 5, register number width (2**ADDR_W registers)
- DEPTH, 2, write-back buffer entries (power of two, >=2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- wb_valid  input  1  write-back request valid
- wb_ready  output  1  buffer can accept a request
- wb_addr  input  ADDR_W  destination register number
- wb_data  input  DATA_W  value to write
- commit_en  input  1  array write port available this cycle
- rd_addr1  input  ADDR_W  read port 1 register number
- rd_data1  output  DATA_W  read port 1 data
- rd_addr2  input  ADDR_W  read port 2 register number
- rd_data2  output  DATA_W  read port 2 data
- wb_count  output  $clog2(DEPTH)+1  buffered entries
- wb_empty  output  1  buffer empty (wb_count==0)

Behaviour:
- One clock (clk); reset is synchronous, active-low (rst_n), sampled on the rising edge.
- Reset: all 32 registers cleared to 0, buffer emptied (wb_count=0, wb_empty=1, wb_ready=1). Reset during active traffic discards buffered entries; writes accepted in the reset cycle are dropped.
- Accept: when wb_valid && wb_ready && wb_addr!=0, the entry is pushed at the clock edge. When wb_addr==0, the handshake still completes, but nothing is enqueued and no state changes.
- wb_ready = (wb_count < DEPTH), a function of registered state only, with no combinational path from wb_valid or commit_en.
- Commit: on each edge with commit_en==1 && !wb_empty, the head entry is written to the array and popped. Strictly in order, at most one commit per cycle.
- Latency: an entry accepted at edge N commits at the first edge M>N with commit_en=1. The minimum is edge N+1, so a request never commits in the cycle it is accepted.
- Simultaneous push and pop: wb_count is unchanged and the pointers both advance. Pointers wrap modulo DEPTH.
- Full: wb_ready=0. wb_valid is ignored, and the source must hold the request.
- Empty with commit_en=1: no action.
- Read ports (combinational, identical logic per port), highest priority first:
  1. rd_addr==0 -> 0.
  2. Incoming accepted write this cycle (wb_valid && wb_ready && wb_addr==rd_addr) -> wb_data.
  3. Youngest buffered entry with matching address -> its data.
  4. Otherwise -> array contents.
- Multiple buffered entries to the same register are legal. Both are committed in order, so the final array value is the younger one.
- wb_count/wb_empty are registered and update at the edge.

Test Plan:
- Reset, then read all 32 registers on both ports -> all 0. wb_ready=1, wb_count=0.
- commit_en=1. Write r5=0xDEADBEEF at edge 1 -> rd_data1(rd_addr1=5) equals 0xDEADBEEF during the accept cycle (bypass), and the array holds it after edge 2. wb_count goes 1 then 0.
- commit_en=0. Push r3=0x11, then r3=0x22 -> wb_count=2, wb_ready=0, rd_data2(3)=0x22. A third push of r4=0x33 is held. Raise commit_en -> r4 is accepted after one pop, and the final r3=0x22, r4=0x33.
- Write r0=0xFFFFFFFF with commit_en=1 -> wb_ready stays 1, wb_count stays 0, rd_data(0)=0.
- With count=1 and commit_en=1, push r7=0xA5 while the head pops -> wb_count stays 1, and r7 reads 0xA5 both before and after its commit.
- With 2 entries buffered (r9, r10), assert rst_n=0 for one cycle -> wb_count=0, and r9/r10 read 0.
